// File: rtl/cc_pkg.sv
// Shared constants and types for the condition-code flag unit.
package cc_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;

    localparam int unsigned DEF_NFLAGS = 2;
    localparam int unsigned DEF_CTRL_W = 3;
    localparam int unsigned DEF_CNT_W  = 2;

    typedef logic [DEF_NFLAGS-1:0] flag_vec_t;

endpackage

// File: rtl/cc_flag_unit_if.sv
// Issue / writeback / decode signal bundle of the flag unit.
interface cc_flag_unit_if
    import cc_pkg::*;
#(
    parameter int unsigned NFLAGS = DEF_NFLAGS,
    parameter int unsigned CTRL_W = DEF_CTRL_W
);
    logic              iss_valid;
    logic [NFLAGS-1:0] iss_wmask;
    logic              iss_full;
    logic              wb_valid;
    logic [NFLAGS-1:0] wb_wmask;
    logic [NFLAGS-1:0] wb_flags;
    logic [CTRL_W-1:0] wb_ctrl;
    logic              flush;
    logic [NFLAGS-1:0] rd_need;
    logic [NFLAGS-1:0] flags_out;
    logic              flag_hazard;
    logic [CTRL_W-1:0] ctrl_out;
    logic              ctrl_valid;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output iss_valid, iss_wmask, wb_valid, wb_wmask, wb_flags, wb_ctrl, flush, rd_need,
        input  iss_full, flags_out, flag_hazard, ctrl_out, ctrl_valid, err_ovf, err_unf
    );

    modport slave (
        input  iss_valid, iss_wmask, wb_valid, wb_wmask, wb_flags, wb_ctrl, flush, rd_need,
        output iss_full, flags_out, flag_hazard, ctrl_out, ctrl_valid, err_ovf, err_unf
    );

endinterface

// File: rtl/cc_pending_ctr.sv
// Per-flag count of in-flight writers: increments on issue, decrements on commit, clears on flush.
module cc_pending_ctr #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec_req,
    input  logic clr,
    output logic at_max,
    output logic pend,
    output logic unf
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nonzero;
    logic             dec;

    always_comb begin
        nonzero = (cnt_q != '0);
        at_max  = (cnt_q == CntMax);
        dec     = dec_req & nonzero;
        // Pending view as seen after this cycle's commit retires its writer.
        pend    = ((cnt_q - CNT_W'(dec)) != '0);
        unf     = dec_req & ~nonzero & ~clr;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cc_flag_unit.sv
// Architectural condition flags with masked writeback, writeback bypass to decode,
// per-flag pending-writer tracking for hazard detection, and a registered ctrl sideband.
module cc_flag_unit
    import cc_pkg::*;
#(
    parameter int unsigned NFLAGS = DEF_NFLAGS,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    cc_flag_unit_if.slave bus
);

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    logic [NFLAGS-1:0] commit;
    logic [NFLAGS-1:0] at_max;
    logic [NFLAGS-1:0] pend;
    logic [NFLAGS-1:0] unf;
    logic              iss_full;
    logic              iss_acc;

    // Deliberately uses only the registered counts so the full path stays short.
    assign iss_full = bus.iss_valid & |(bus.iss_wmask & at_max);
    assign iss_acc  = bus.iss_valid & ~iss_full & ~bus.flush;
    assign commit   = {NFLAGS{bus.wb_valid}} & bus.wb_wmask;

    for (genvar f = 0; f < NFLAGS; f++) begin : g_ctr
        cc_pending_ctr #(
            .CNT_W (CNT_W)
        ) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .inc     (iss_acc & bus.iss_wmask[f]),
            .dec_req (commit[f]),
            .clr     (bus.flush),
            .at_max  (at_max[f]),
            .pend    (pend[f]),
            .unf     (unf[f])
        );
    end

    always_comb begin
        flags_d      = (commit & bus.wb_flags) | (~commit & flags_q);
        ctrl_d       = bus.wb_ctrl;
        ctrl_valid_d = bus.wb_valid;
        err_ovf_d    = err_ovf_q | iss_full;
        err_unf_d    = err_unf_q | (|unf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
        end
    end

    assign bus.iss_full    = iss_full;
    assign bus.flags_out   = flags_d;
    assign bus.flag_hazard = |(bus.rd_need & pend) & ~bus.flush;
    assign bus.ctrl_out    = ctrl_q;
    assign bus.ctrl_valid  = ctrl_valid_q;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_unf     = err_unf_q;

endmodule

// File: tb/tb_cc_flag_unit.sv
// Randomized and directed check of cc_flag_unit against a counting reference model.
module tb_cc_flag_unit;
    import cc_pkg::*;

    localparam int unsigned NF   = DEF_NFLAGS;
    localparam int unsigned CW   = DEF_CTRL_W;
    localparam int          CMAX = (1 << DEF_CNT_W) - 1;

    logic clk;
    logic reset;

    cc_flag_unit_if #(.NFLAGS(NF), .CTRL_W(CW)) bus ();

    cc_flag_unit #(
        .NFLAGS (NF),
        .CTRL_W (CW),
        .CNT_W  (DEF_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int     m_cnt [NF];
    bit     m_flag[NF];
    bit     m_ovf, m_unf, m_cv;
    int     m_ctrl;
    bit     m_ok = 0;

    logic [NF-1:0] last_flags;
    logic          last_hazard, last_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit iv, input logic [NF-1:0] iw,
                         input bit wv, input logic [NF-1:0] ww, input logic [NF-1:0] wf,
                         input logic [CW-1:0] wc, input bit fl, input logic [NF-1:0] rn);
        bit            full, acc, haz, commit;
        logic [NF-1:0] fo;
        reset         = rst;
        bus.iss_valid = iv;
        bus.iss_wmask = iw;
        bus.wb_valid  = wv;
        bus.wb_wmask  = ww;
        bus.wb_flags  = wf;
        bus.wb_ctrl   = wc;
        bus.flush     = fl;
        bus.rd_need   = rn;
        #3;
        full = 0;
        haz  = 0;
        for (int f = 0; f < NF; f++) begin
            commit = wv && ww[f];
            if (iv && iw[f] && m_cnt[f] == CMAX) full = 1;
            fo[f] = commit ? wf[f] : m_flag[f];
            if (rn[f] && (m_cnt[f] - ((commit && m_cnt[f] > 0) ? 1 : 0)) > 0) haz = 1;
        end
        if (fl) haz = 0;
        acc = iv && !full && !fl;
        last_flags  = bus.flags_out;
        last_hazard = bus.flag_hazard;
        last_full   = bus.iss_full;
        if (m_ok) begin
            check("flags_out",   32'(bus.flags_out),   32'(fo));
            check("flag_hazard", 32'(bus.flag_hazard), 32'(haz));
            check("iss_full",    32'(bus.iss_full),    32'(full));
            check("ctrl_out",    32'(bus.ctrl_out),    32'(m_ctrl));
            check("ctrl_valid",  32'(bus.ctrl_valid),  32'(m_cv));
            check("err_ovf",     32'(bus.err_ovf),     32'(m_ovf));
            check("err_unf",     32'(bus.err_unf),     32'(m_unf));
        end
        @(posedge clk);
        if (rst) begin
            for (int f = 0; f < NF; f++) begin
                m_cnt[f]  = 0;
                m_flag[f] = 0;
            end
            m_ovf = 0; m_unf = 0; m_cv = 0; m_ctrl = 0;
            m_ok  = 1;
        end else begin
            for (int f = 0; f < NF; f++) begin
                commit = wv && ww[f];
                if (commit) m_flag[f] = wf[f];
                if (commit && m_cnt[f] == 0 && !fl) m_unf = 1;
                if (fl) m_cnt[f] = 0;
                else m_cnt[f] = m_cnt[f] + ((acc && iw[f]) ? 1 : 0)
                                - ((commit && m_cnt[f] > 0) ? 1 : 0);
            end
            if (full) m_ovf = 1;
            m_cv   = wv;
            m_ctrl = int'(wc);
        end
        #1;
    endtask

    task automatic idle(input logic [NF-1:0] rn);
        cycle(0, 0, '0, 0, '0, '0, '0, 0, rn);
    endtask

    initial begin
        reset = 1'b1;
        #1;
        // 1: reset with random inputs
        for (int i = 0; i < 2; i++)
            cycle(1, 1'($urandom), NF'($urandom), 1'($urandom), NF'($urandom), NF'($urandom),
                  CW'($urandom), 1'($urandom), NF'($urandom));
        idle('1);
        check("rst_flags", 32'(last_flags), 32'h0);
        check("rst_hazard", 32'(last_hazard), 32'h0);

        // 2: hazard then commit with bypass
        cycle(0, 1, 2'b11, 0, '0, '0, '0, 0, '0);
        idle(2'b01);
        check("t2_hazard", 32'(last_hazard), 32'h1);
        cycle(0, 0, '0, 1, 2'b11, 2'b10, '0, 0, 2'b01);
        check("t2_bypass", 32'(last_flags), 32'h2);
        check("t2_hazard_clr", 32'(last_hazard), 32'h0);
        idle('0);
        check("t2_reg", 32'(last_flags), 32'h2);

        // 3: saturate C counter
        for (int i = 0; i < 3; i++) cycle(0, 1, 2'b01, 0, '0, '0, '0, 0, '0);
        cycle(0, 1, 2'b01, 0, '0, '0, '0, 0, '0);
        check("t3_full", 32'(last_full), 32'h1);
        idle(2'b01);
        check("t3_ovf", 32'(bus.err_ovf), 32'h1);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 2'b01, 2'b01, '0, 0, '0);
        idle(2'b01);
        check("t3_drained", 32'(last_hazard), 32'h0);

        // 4: simultaneous issue and commit
        cycle(0, 1, 2'b01, 0, '0, '0, '0, 0, '0);
        cycle(0, 1, 2'b01, 1, 2'b01, 2'b00, '0, 0, 2'b01);
        check("t4_hazard", 32'(last_hazard), 32'h0);
        idle(2'b01);
        check("t4_cnt1", 32'(last_hazard), 32'h1);
        cycle(0, 0, '0, 1, 2'b01, 2'b00, '0, 0, '0);

        // 5: flush with commit and issue
        cycle(0, 1, 2'b01, 0, '0, '0, '0, 0, '0);
        cycle(0, 1, 2'b01, 0, '0, '0, '0, 0, '0);
        cycle(0, 1, 2'b01, 1, 2'b01, 2'b01, '0, 1, 2'b01);
        idle(2'b01);
        check("t5_hazard", 32'(last_hazard), 32'h0);
        check("t5_c", 32'(last_flags[FLAG_C]), 32'h1);

        // 6: underflow on Z and ctrl pipe
        cycle(0, 0, '0, 1, 2'b10, 2'b10, 3'b101, 0, '0);
        idle('0);
        check("t6_unf", 32'(bus.err_unf), 32'h1);
        check("t6_z", 32'(last_flags[FLAG_Z]), 32'h1);

        // Random traffic, with occasional reset and flush
        for (int i = 0; i < 2000; i++)
            cycle(($urandom_range(0, 99) == 0), 1'($urandom), NF'($urandom),
                  1'($urandom), NF'($urandom), NF'($urandom), CW'($urandom),
                  ($urandom_range(0, 19) == 0), NF'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
